trace_record_builder: RTL
=========================

TRACE_RECORD_BUILDER -- requirements
Module: trace_record_builder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, fetch address width.
REQ-003 SHALL have parameter TS_WIDTH, default 32, timestamp width.
REQ-004 SHALL have parameter NUM_EVT, default 8, number of ordered per-instruction events (min 2).
REQ-005 SHALL have parameter DEPTH, default 4, number of in-flight records (power of two, min 2).
REQ-006 SHALL have parameter INSTR_EVT, default 1, index of the event that captures the instruction word (0..NUM_EVT-1).
REQ-007 SHALL have port clk  input  1  the single clock, all state on rising edge.
REQ-008 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-009 SHALL have port evt_i  input  NUM_EVT  one-cycle event strobes; bit 0 allocates a record; bit NUM_EVT-1 completes it.
REQ-010 SHALL have port addr_i  input  ADDR_WIDTH  fetch address, sampled with evt_i[0].
REQ-011 SHALL have port pass_through_i  input  1  pass-through flag, sampled with evt_i[0].
REQ-012 SHALL have port instr_i  input  DATA_WIDTH  instruction, sampled with evt_i[INSTR_EVT].
REQ-013 SHALL have port clr_i  input  1  synchronous clear of sticky flags and drop counter.
REQ-014 SHALL have port out_valid_o  output  1  head record complete.
REQ-015 SHALL have port out_ready_i  input  1  consumer accepts head record.
REQ-016 SHALL have port out_addr_o, out_instr_o, out_pass_through_o  output  ADDR_WIDTH/DATA_WIDTH/1  head record fields.
REQ-017 SHALL have port out_ts_o  output  NUM_EVT*TS_WIDTH  head timestamps; event k at bits [k*TS_WIDTH +: TS_WIDTH].
REQ-018 SHALL have port occupancy_o  output  clog2(DEPTH)+1  allocated, not-yet-popped records.
REQ-019 SHALL have ports overflow_o, seq_err_o  output  1 each  sticky error flags; drop_cnt_o  output  8  saturating dropped-allocation count.

Function
REQ-020 SHALL run a free-running TS_WIDTH cycle counter, incrementing every cycle, wrapping modulo 2^TS_WIDTH.
REQ-021 SHALL hold one pointer and count per event; event k applies to the oldest record that has not yet seen event k (in-order).
REQ-022 SHALL write the counter value of the event cycle into that record's slot k; the pointer advances one slot, wrapping at DEPTH.
REQ-023 SHALL accept evt_i[k], k>0, only if the target record has seen event k-1, including event k-1 in the same cycle (both get the same timestamp).
REQ-024 SHALL drop an unacceptable evt_i[k], k>0, and set seq_err_o; no record state changes.
REQ-025 SHALL drop evt_i[0] when registered occupancy equals DEPTH, even if a pop occurs the same cycle; set overflow_o; increment drop_cnt_o, saturating at 255.
REQ-026 SHALL assert out_valid_o the cycle after the head record receives event NUM_EVT-1; output fields SHALL be stable while out_valid_o is high and out_ready_i is low.
REQ-027 SHALL pop the head on out_valid_o && out_ready_i, freeing its slot and decrementing occupancy.
REQ-028 SHALL, on simultaneous allocate and pop with occupancy below DEPTH, leave occupancy unchanged.
REQ-029 SHALL give clr_i priority over setting events in the same cycle: flags and counter read 0 afterward.
REQ-030 SHALL not clear in-flight records on clr_i.

Reset
REQ-031 SHALL, on rst, asynchronously clear timestamp counter, all pointers and counts, occupancy_o, out_valid_o, overflow_o, seq_err_o and drop_cnt_o to 0; record storage need not be reset.
REQ-032 SHALL, with rst asserted mid-operation, discard all in-flight records; out_valid_o SHALL be 0 from the first cycle after release until a new record completes.

Verification
REQ-033 SHALL cover: evt_i[0..7] on cycles 10..17, out_ready_i=1 -> out_valid_o high at cycle 18, out_ts_o slots = 10..17, occupancy_o returns 0.
REQ-034 SHALL cover: evt_i[0] and evt_i[1] same cycle 5 -> slots 0 and 1 both 5; evt_i[3] with no prior evt_i[2] -> seq_err_o=1, record unchanged.
REQ-035 SHALL cover: DEPTH=4, five allocations, out_ready_i=0 -> occupancy_o=4, overflow_o=1, drop_cnt_o=1; 300 further allocations -> drop_cnt_o=255.
REQ-036 SHALL cover: three records interleaved in pipeline fashion, out_ready_i toggling -> records emitted in allocation order, fields stable while stalled.
REQ-037 SHALL cover: TS_WIDTH=4, events straddling counter wrap -> timestamps 14, 15, 0, 1.
REQ-038 SHALL cover: rst pulse with two records in flight -> all outputs 0; next record completes with correct timestamps relative to counter restart at 0.

Source files
------------

// File: rtl/trace_record_builder.sv
`default_nettype none
// ============================================================================
//  Module   : trace_record_builder
//  Purpose  : Builds in-order per-instruction trace records from event strobes.
//  Revision : 1.0
// ============================================================================
module trace_record_builder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TS_WIDTH   = 32,
    parameter int NUM_EVT    = 8,
    parameter int DEPTH      = 4,
    parameter int INSTR_EVT  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_EVT-1:0]            evt_i,
    input  logic [ADDR_WIDTH-1:0]         addr_i,
    input  logic                          pass_through_i,
    input  logic [DATA_WIDTH-1:0]         instr_i,
    input  logic                          clr_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [ADDR_WIDTH-1:0]         out_addr_o,
    output logic [DATA_WIDTH-1:0]         out_instr_o,
    output logic                          out_pass_through_o,
    output logic [NUM_EVT*TS_WIDTH-1:0]   out_ts_o,
    output logic [$clog2(DEPTH):0]        occupancy_o,
    output logic                          overflow_o,
    output logic                          seq_err_o,
    output logic [7:0]                    drop_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [TS_WIDTH-1:0]   ts_cnt;
    logic [PW-1:0]         ptr [NUM_EVT];
    logic [CW-1:0]         cnt [NUM_EVT];
    logic [PW-1:0]         head;
    logic [NUM_EVT-1:0]    acc;
    logic                  pop;
    logic                  seq_bad;
    logic                  alloc_drop;

    logic [ADDR_WIDTH-1:0] addr_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
    logic                  pass_mem  [DEPTH];
    logic [TS_WIDTH-1:0]   ts_mem    [DEPTH][NUM_EVT];

    // cnt[k] = in-flight records that have already seen event k, so
    // cnt[k-1] > cnt[k] means some record is waiting for event k.
    always_comb begin
        logic chain;
        acc     = '0;
        acc[0]  = evt_i[0] && (cnt[0] != CW'(DEPTH));
        chain   = acc[0];
        for (int k = 1; k < NUM_EVT; k++) begin
            acc[k] = evt_i[k] && ((cnt[k-1] > cnt[k]) || chain);
            chain  = acc[k];
        end
    end

    assign out_valid_o = (cnt[NUM_EVT-1] != '0);
    assign pop         = out_valid_o && out_ready_i;
    assign seq_bad     = |(evt_i[NUM_EVT-1:1] & ~acc[NUM_EVT-1:1]);
    assign alloc_drop  = evt_i[0] && !acc[0];
    assign occupancy_o = cnt[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt     <= '0;
            head       <= '0;
            overflow_o <= 1'b0;
            seq_err_o  <= 1'b0;
            drop_cnt_o <= 8'd0;
            for (int k = 0; k < NUM_EVT; k++) begin
                ptr[k] <= '0;
                cnt[k] <= '0;
            end
        end else begin
            ts_cnt <= ts_cnt + TS_WIDTH'(1);
            for (int k = 0; k < NUM_EVT; k++) begin
                if (acc[k]) ptr[k] <= ptr[k] + PW'(1);
                cnt[k] <= cnt[k] + CW'(acc[k]) - CW'(pop);
            end
            if (pop) head <= head + PW'(1);
            if (clr_i) begin
                overflow_o <= 1'b0;
                seq_err_o  <= 1'b0;
                drop_cnt_o <= 8'd0;
            end else begin
                if (seq_bad)    seq_err_o  <= 1'b1;
                if (alloc_drop) overflow_o <= 1'b1;
                if (alloc_drop && drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
            end
        end
    end

    // Record payload carries no reset; validity is tracked purely by cnt[].
    always_ff @(posedge clk) begin
        if (acc[0]) begin
            addr_mem[ptr[0]] <= addr_i;
            pass_mem[ptr[0]] <= pass_through_i;
        end
        if (acc[INSTR_EVT]) instr_mem[ptr[INSTR_EVT]] <= instr_i;
        for (int k = 0; k < NUM_EVT; k++) begin
            if (acc[k]) ts_mem[ptr[k]][k] <= ts_cnt;
        end
    end

    always_comb begin
        out_addr_o         = '0;
        out_instr_o        = '0;
        out_pass_through_o = 1'b0;
        out_ts_o           = '0;
        if (out_valid_o) begin
            out_addr_o         = addr_mem[head];
            out_instr_o        = instr_mem[head];
            out_pass_through_o = pass_mem[head];
            for (int k = 0; k < NUM_EVT; k++) begin
                out_ts_o[k*TS_WIDTH +: TS_WIDTH] = ts_mem[head][k];
            end
        end
    end

endmodule
`default_nettype wire
